// File: rtl/bp_me_trace_pkg.sv
// Shared definitions for the trace replay driver.
//   bp_me_trace_op_e     : 4-bit command-ROM opcodes.
//   bp_me_trace_state_e  : driver control states.
//   `BP_ME_TRACE_DECLARE_ROM_ENTRY_S(ring_width) : ROM entry layout
//        {op[3:0], payload[ring_width-1:0]}, op in the top four bits.
package bp_me_trace_pkg;

  typedef enum logic [3:0] {
    e_op_nop  = 4'h0,
    e_op_send = 4'h1,
    e_op_recv = 4'h2,
    e_op_wait = 4'h3,
    e_op_done = 4'hF
  } bp_me_trace_op_e;

  typedef enum logic [1:0] {
    eRun  = 2'd0,
    eWait = 2'd1,
    eDone = 2'd2
  } bp_me_trace_state_e;

endpackage

`ifndef BP_ME_TRACE_ROM_ENTRY_MACRO
`define BP_ME_TRACE_ROM_ENTRY_MACRO
`define BP_ME_TRACE_DECLARE_ROM_ENTRY_S(ring_width_mp) \
  typedef struct packed { \
    logic [3:0]               op; \
    logic [ring_width_mp-1:0] payload; \
  } bp_me_trace_rom_entry_s
`endif

// File: rtl/bp_me_trace_replay_driver.sv
// Trace replay driver: walks a command ROM and turns each entry into
// traffic toward the mock LCE.
//   clk_i, reset_n_i      : clock, asynchronous active-low reset.
//   en_i                  : global enable; low freezes PC, wait counter and
//                           suppresses both handshakes.
//   rom_addr_o/rom_data_i : registered PC out, combinational ROM entry in.
//   tr_pkt_o/_v_o/_yumi_i : outgoing packet, valid-yumi handshake.
//   tr_pkt_i/_v_i/_ready_o: returned packet, valid-ready handshake.
//   done_o                : program reached DONE (or aborted on error).
//   error_o               : sticky mismatch / illegal op / PC overflow.
//   mismatch_cnt_o        : saturating count of RECV compare failures.
module bp_me_trace_replay_driver
  import bp_me_trace_pkg::*;
#(
  parameter int ring_width_p      = 125,
  parameter int rom_addr_width_p  = 20,
  parameter int wait_width_p      = 16,
  parameter int cnt_width_p       = 16,
  localparam int rom_data_width_lp = 4 + ring_width_p
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         en_i,
  output logic [rom_addr_width_p-1:0]  rom_addr_o,
  input  logic [rom_data_width_lp-1:0] rom_data_i,
  output logic [ring_width_p-1:0]      tr_pkt_o,
  output logic                         tr_pkt_v_o,
  input  logic                         tr_pkt_yumi_i,
  input  logic [ring_width_p-1:0]      tr_pkt_i,
  input  logic                         tr_pkt_v_i,
  output logic                         tr_pkt_ready_o,
  output logic                         done_o,
  output logic                         error_o,
  output logic [cnt_width_p-1:0]       mismatch_cnt_o
);

  `BP_ME_TRACE_DECLARE_ROM_ENTRY_S(ring_width_p);

  bp_me_trace_rom_entry_s  entry;
  bp_me_trace_op_e         op;
  logic [wait_width_p-1:0] wait_n;

  assign entry  = rom_data_i;
  assign op     = bp_me_trace_op_e'(entry.op);
  assign wait_n = entry.payload[wait_width_p-1:0];

  bp_me_trace_state_e          state_r, state_n;
  logic [rom_addr_width_p-1:0] pc_r, pc_n;
  logic [wait_width_p-1:0]     wait_r, wait_nxt;
  logic [cnt_width_p-1:0]      cnt_r, cnt_n;
  logic                        err_r, err_n;
  logic                        adv;
  logic                        pkt_v, pkt_ready;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= eRun;
      pc_r    <= '0;
      wait_r  <= '0;
      cnt_r   <= '0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      pc_r    <= pc_n;
      wait_r  <= wait_nxt;
      cnt_r   <= cnt_n;
      err_r   <= err_n;
    end
  end

  always_comb begin
    state_n   = state_r;
    pc_n      = pc_r;
    wait_nxt  = wait_r;
    cnt_n     = cnt_r;
    err_n     = err_r;
    adv       = 1'b0;
    pkt_v     = 1'b0;
    pkt_ready = 1'b0;

    unique case (state_r)
      eRun: begin
        unique case (op)
          e_op_nop:  adv = en_i;
          e_op_send: begin
            pkt_v = en_i;
            adv   = en_i & tr_pkt_yumi_i;
          end
          e_op_recv: begin
            pkt_ready = en_i;
            if (en_i && tr_pkt_v_i) begin
              adv = 1'b1;
              if (tr_pkt_i != entry.payload) begin
                err_n = 1'b1;
                if (cnt_r != '1) cnt_n = cnt_r + 1'b1;
              end
            end
          end
          e_op_wait: begin
            if (en_i) begin
              // WAIT 0 is a one-cycle entry; otherwise eWait
              // burns the remaining n cycles.
              if (wait_n == '0) begin
                adv = 1'b1;
              end else begin
                wait_nxt = wait_n;
                state_n  = eWait;
              end
            end
          end
          e_op_done: if (en_i) state_n = eDone;
          default: begin
            if (en_i) begin
              err_n   = 1'b1;
              state_n = eDone;
            end
          end
        endcase
      end
      eWait: begin
        if (en_i) begin
          if (wait_r == wait_width_p'(1)) begin
            adv     = 1'b1;
            state_n = eRun;
          end else begin
            wait_nxt = wait_r - 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Running off the end of the ROM is an error, never a wrap to 0.
    if (adv) begin
      if (&pc_r) begin
        err_n   = 1'b1;
        state_n = eDone;
      end else begin
        pc_n = pc_r + 1'b1;
      end
    end
  end

  // Handshake outputs are forced low while reset is held, even though the
  // cleared state may point at a SEND/RECV entry.
  assign tr_pkt_v_o     = pkt_v & reset_n_i;
  assign tr_pkt_ready_o = pkt_ready & reset_n_i;
  assign tr_pkt_o       = entry.payload;
  assign rom_addr_o     = pc_r;
  assign done_o         = (state_r == eDone);
  assign error_o        = err_r;
  assign mismatch_cnt_o = cnt_r;

endmodule
